muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle RV32M execute unit. Takes rdata1/rdata2 from the register file
//  as operands a/b and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//  Returns result plus destination index to writeback, which drives the
//  register file's regwrite/waddr/wdata. Stalls the front end via in_ready.
// PARAMETERS
//  XLEN      32  operand/result width; only 32 is supported
//  DIV_STEPS 32  restoring-divider iterations; must equal XLEN
// PORTS
//  clk        in   1     clock; all state updates on rising edge
//  reset      in   1     asynchronous, active-high; clears all state
//  in_valid   in   1     operation request
//  in_ready   out  1     high only in IDLE; accept = in_valid & in_ready & !flush
//  op         in   3     funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                        100 DIV, 101 DIVU, 110 REM, 111 REMU
//  a          in   32    rs1 value
//  b          in   32    rs2 value
//  rd         in   5     destination register, carried through unchanged
//  flush      in   1     synchronous kill of any in-flight op
//  out_valid  out  1     result available; held until out_ready
//  out_ready  in   1     writeback consumes the result
//  result     out  32    computed value
//  out_rd     out  5     rd of the op being returned
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset: async, active-high. Sets state=IDLE, out_valid=0, result=0,
//   out_rd=0, busy=0, in_ready=1 (in_ready=1 once reset is released).
//  On accept, op/a/b/rd are registered. Inputs are don't-care afterwards.
//  FSM states: IDLE, MUL, DIV, FIX, DONE.
//   IDLE -> MUL   on MUL* op.
//   IDLE -> FIX   on div op with b==0, or signed DIV/REM with a==0x80000000,
//                 b==0xFFFFFFFF.
//   IDLE -> DIV   on any other div op.
//   MUL  -> DONE  after one cycle; 33x33 signed product of sign/zero-extended
//                 operands (MULH s*s, MULHSU s*u, MULHU u*u). MUL returns the
//                 low 32 bits; the others return bits [63:32].
//   DIV  -> FIX   after exactly 32 cycles; unsigned restoring division on
//                 operand magnitudes, 6-bit counter 31..0.
//   FIX  -> DONE  applies signs. Quotient is negative iff signs differ;
//                 remainder takes the dividend's sign.
//   DONE -> IDLE  when out_ready=1.
//  Special results (computed in FIX):
//   divide by zero: quotient = 0xFFFFFFFF, remainder = a.
//   signed overflow: quotient = 0x80000000, remainder = 0.
//  Latency, counted in rising edges from the accept edge to out_valid=1:
//   MUL*  = 2, special div = 2, normal div = 34.
//  out_valid, result and out_rd stay stable while out_valid=1 && !out_ready.
//   No new accept occurs until DONE->IDLE. in_ready=0 in DONE.
//  flush: any state -> IDLE at the next edge; out_valid=0 from that edge on.
//   flush overrides in_valid in the same cycle (no accept). flush in DONE with
//   out_ready=1: the result is dropped (flush wins).
//  rd==0 is computed normally. Discarding x0 writes is the register file's job.
//  No combinational path from in_* to out_*. in_ready depends only on state.
// STRUCTURE
//  Package muldiv_pkg:
//   md_op_e enum with the funct3 encodings above.
//   md_state_e enum: IDLE, MUL, DIV, FIX, DONE.
//   constants MD_INT_MIN = 32'h8000_0000 and MD_ALL_ONES = 32'hFFFF_FFFF.
//  Sub-module md_divider: iterative unsigned restoring core.
//   Signals: start, dividend, divisor -> quotient, remainder, done.
//   Instantiated once. Sign handling and the FSM stay in muldiv_unit.
// TESTING
//  1. MUL a=7, b=0xFFFFFFFD, rd=5 -> result 0xFFFFFFEB, out_rd=5;
//     out_valid 2 edges after accept.
//  2. a=b=0x80000000: MULH -> 0x40000000. a=b=0xFFFFFFFF: MULHSU -> 0xFFFFFFFF,
//     MULHU -> 0xFFFFFFFE.
//  3. a=0xFFFFFFF9 (-7), b=2: DIV -> 0xFFFFFFFD, REM -> 0xFFFFFFFF,
//     DIVU -> 0x7FFFFFFC; out_valid 34 edges after accept; in_ready=0 meanwhile.
//  4. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF
//     -> 0x80000000; REM same operands -> 0. Each with latency 2.
//  5. Backpressure: out_ready=0 for 5 cycles in DONE -> result/out_rd stable,
//     in_ready=0. in_valid held high is accepted only the cycle after the
//     out_ready handshake.
//  6. flush on DIV cycle 10 -> IDLE next edge, no out_valid. reset pulse
//     mid-DIV (between edges) -> out_valid/busy=0 immediately. Next op correct.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;
    localparam int XLEN      = 32;
    localparam int DIV_STEPS = 32;
    localparam logic [31:0] MD_INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] MD_ALL_ONES = 32'hFFFF_FFFF;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} md_state_e;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response handshake between the front end, the unit and writeback.
interface muldiv_if;
    import muldiv_pkg::*;
    logic        in_valid;
    logic        in_ready;
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  out_rd;
    logic        busy;
    modport master (output in_valid, op, a, b, rd, flush, out_ready,
                    input in_ready, out_valid, result, out_rd, busy);
    modport slave (input in_valid, op, a, b, rd, flush, out_ready,
                   output in_ready, out_valid, result, out_rd, busy);
endinterface

// File: rtl/muldiv_divider.sv
// md_divider: iterative unsigned restoring divider, one quotient bit per cycle.
module md_divider
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);
    logic [31:0] q_q, r_q, d_q;
    logic [5:0]  cnt_q;
    logic        act_q;
    logic [32:0] sh, diff;
    assign sh        = {r_q, q_q[31]};
    assign diff      = sh - {1'b0, d_q};
    assign done      = act_q && cnt_q == '0;
    assign quotient  = q_q;
    assign remainder = r_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q   <= '0;
            r_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else if (start) begin
            q_q   <= dividend;
            r_q   <= '0;
            d_q   <= divisor;
            cnt_q <= 6'(DIV_STEPS - 1);
            act_q <= 1'b1;
        end else if (act_q) begin
            // Keep the trial difference only when it did not borrow.
            r_q   <= diff[32] ? sh[31:0] : diff[31:0];
            q_q   <= {q_q[30:0], !diff[32]};
            cnt_q <= cnt_q - 6'd1;
            act_q <= cnt_q != '0;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic clk,
    input  logic reset,
    muldiv_if.slave io
);
    md_state_e   state_q, state_d;
    md_op_e      op_q;
    logic [31:0] a_q, b_q, result_q;
    logic [4:0]  rd_q;
    logic        accept, special, in_signed, div_start, div_done;
    logic        sa, sb, q_signed, div0, ovf;
    logic [31:0] mag_a, mag_b, quo, rem, q_fix, r_fix, mul_res, div_res;
    logic [63:0] pa, pb, prod;
    assign in_signed = !io.op[0];
    assign accept    = io.in_valid && state_q == IDLE && !io.flush;
    assign special   = io.b == '0 || (in_signed && io.a == MD_INT_MIN && io.b == MD_ALL_ONES);
    assign mag_a     = in_signed && io.a[31] ? -io.a : io.a;
    assign mag_b     = in_signed && io.b[31] ? -io.b : io.b;
    assign div_start = accept && io.op[2];
    md_divider u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quo),
        .remainder (rem),
        .done      (div_done)
    );
    // Low 64 bits of the 33x33 signed product equal those of the sign-extended 64x64 product.
    assign sa      = op_q[1:0] != 2'b11 && a_q[31];
    assign sb      = !op_q[1] && b_q[31];
    assign pa      = {{32{sa}}, a_q};
    assign pb      = {{32{sb}}, b_q};
    assign prod    = pa * pb;
    assign mul_res = op_q[1:0] == 2'b00 ? prod[31:0] : prod[63:32];
    assign q_signed = !op_q[0];
    assign div0     = b_q == '0;
    assign ovf      = q_signed && a_q == MD_INT_MIN && b_q == MD_ALL_ONES;
    assign q_fix    = div0 ? MD_ALL_ONES : ovf ? MD_INT_MIN : q_signed && (a_q[31] ^ b_q[31]) ? -quo : quo;
    assign r_fix    = div0 ? a_q : ovf ? '0 : q_signed && a_q[31] ? -rem : rem;
    assign div_res  = op_q[1] ? r_fix : q_fix;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.in_valid) state_d = !io.op[2] ? MUL : special ? FIX : DIV;
            MUL:     state_d = DONE;
            DIV:     if (div_done) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (io.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (io.flush) state_d = IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= state_q == MUL ? mul_res : state_q == FIX ? div_res : result_q;
            if (accept) begin
                op_q <= io.op;
                a_q  <= io.a;
                b_q  <= io.b;
                rd_q <= io.rd;
            end
        end
    end
    assign io.in_ready  = state_q == IDLE;
    assign io.out_valid = state_q == DONE;
    assign io.busy      = state_q != IDLE;
    assign io.result    = result_q;
    assign io.out_rd    = rd_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector table plus hand sequences for backpressure, flush and reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;
    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    vec_t vecs[$];
    always #5 clk = ~clk;
    muldiv_if bus();
    muldiv_unit dut (.clk(clk), .reset(reset), .io(bus));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic drive(input md_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.rd = rd;
        bus.in_valid = 1'b1;
    endtask
    // Called at the negedge where the request is driven; returns edges from accept to out_valid.
    task automatic wait_valid(input string name, output int n);
        n = 1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid) return;
            chk({name, "_in_ready_low"}, {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk);
            n++;
        end
        checks++;
        failures++;
        $display("FAIL %s_timeout: got no out_valid want out_valid within 100 edges", name);
        n = -1;
    endtask
    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard: got out_valid want empty queue", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_result"}, bus.result, e.res);
            chk({name, "_out_rd"}, {27'd0, bus.out_rd}, {27'd0, e.rd});
        end
    endtask
    task automatic release_out(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_valid_cleared"}, {31'd0, bus.out_valid}, 32'd0);
        chk({name, "_ready_again"}, {31'd0, bus.in_ready}, 32'd1);
    endtask
    task automatic run_vec(input vec_t v, input string name);
        int n;
        @(negedge clk);
        chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        drive(v.op, v.a, v.b, v.rd);
        sb.push_back('{v.exp, v.rd});
        wait_valid(name, n);
        if (n >= 0) begin
            chk({name, "_latency"}, 32'(n), 32'(v.lat));
            pop_check(name);
        end
        release_out(name);
    endtask
    initial begin
        int n, seen;
        bus.in_valid = 1'b0;
        bus.op = OP_MUL;
        bus.a = '0;
        bus.b = '0;
        bus.rd = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        vecs.push_back('{OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 2});
        vecs.push_back('{OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 2});
        vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF, 2});
        vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, 2});
        vecs.push_back('{OP_MUL,    32'h8000_0000,  32'h8000_0000, 5'd0,  32'h0000_0000, 2});
        vecs.push_back('{OP_MULHU,  32'h1234_5678,  32'h0000_0010, 5'd31, 32'h0000_0001, 2});
        vecs.push_back('{OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD, 34});
        vecs.push_back('{OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd11, 32'hFFFF_FFFF, 34});
        vecs.push_back('{OP_DIVU,   32'hFFFF_FFF9,  32'd2,         5'd12, 32'h7FFF_FFFC, 34});
        vecs.push_back('{OP_REMU,   32'hFFFF_FFF9,  32'd2,         5'd13, 32'h0000_0001, 34});
        vecs.push_back('{OP_DIVU,   32'd5,          32'd0,         5'd14, 32'hFFFF_FFFF, 2});
        vecs.push_back('{OP_REMU,   32'd5,          32'd0,         5'd15, 32'h0000_0005, 2});
        vecs.push_back('{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 2});
        vecs.push_back('{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 2});
        vecs.push_back('{OP_DIV,    32'd100,        32'hFFFF_FFF9, 5'd18, 32'hFFFF_FFF2, 34});
        vecs.push_back('{OP_REM,    32'd100,        32'hFFFF_FFF9, 5'd19, 32'h0000_0002, 34});
        vecs.push_back('{OP_REM,    32'hFFFF_FF9C,  32'd7,         5'd20, 32'hFFFF_FFFE, 34});
        vecs.push_back('{OP_DIV,    32'd0,          32'd0,         5'd21, 32'hFFFF_FFFF, 2});
        vecs.push_back('{OP_REM,    32'hFFFF_FFFB,  32'd0,         5'd0,  32'hFFFF_FFFB, 2});
        vecs.push_back('{OP_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 5'd22, 32'h0000_0000, 34});
        vecs.push_back('{OP_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 5'd23, 32'h8000_0000, 34});
        @(negedge clk);
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_result", bus.result, 32'd0);
        chk("reset_out_rd", {27'd0, bus.out_rd}, 32'd0);
        reset = 1'b0;
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));
        // Backpressure: result held in DONE while a new request waits on in_valid.
        @(negedge clk);
        drive(OP_MUL, 32'd6, 32'd7, 5'd3);
        sb.push_back('{32'd42, 5'd3});
        wait_valid("bp", n);
        chk("bp_latency", 32'(n), 32'd2);
        drive(OP_MUL, 32'd3, 32'd4, 5'd9);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_result", bus.result, 32'd42);
            chk("bp_hold_rd", {27'd0, bus.out_rd}, 32'd3);
            chk("bp_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        pop_check("bp_first");
        bus.out_ready = 1'b1;
        sb.push_back('{32'd12, 5'd9});
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_after_handshake", {31'd0, bus.busy}, 32'd0);
        chk("bp_ready_after_handshake", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_accepted", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_second_valid", {31'd0, bus.out_valid}, 32'd1);
        pop_check("bp_second");
        release_out("bp_second");
        // Flush during DIV.
        @(negedge clk);
        drive(OP_DIV, 32'd100, 32'd7, 5'd4);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("flush_pre_busy", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        // Flush overrides in_valid in the same cycle.
        @(negedge clk);
        drive(OP_MUL, 32'd2, 32'd3, 5'd2);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_vs_accept_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        chk("flush_vs_accept_valid", {31'd0, bus.out_valid}, 32'd0);
        // Flush in DONE wins over out_ready.
        @(negedge clk);
        drive(OP_MUL, 32'd2, 32'd2, 5'd1);
        wait_valid("flush_done", n);
        chk("flush_done_latency", 32'(n), 32'd2);
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("flush_done_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_done_busy", {31'd0, bus.busy}, 32'd0);
        // Asynchronous reset pulse mid-DIV.
        @(negedge clk);
        drive(OP_DIVU, 32'd1000, 32'd3, 5'd12);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("rst_pre_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_async_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_async_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_async_result", bus.result, 32'd0);
        chk("rst_async_out_rd", {27'd0, bus.out_rd}, 32'd0);
        #1;
        reset = 1'b0;
        run_vec('{OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd25, 32'hFFFF_FFF2, 34}, "post_rst");
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
